// File: rtl/cla_addsub_pipe_if.sv
// rtl/cla_addsub_pipe_if.sv - operand, carry-generator and result signals of cla_addsub_pipe
interface cla_addsub_pipe_if #(
    parameter int WIDTH = 8
);
    // operand side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;

    // carry look-ahead generator side
    logic [WIDTH-1:0] g_out;
    logic [WIDTH-1:0] p_out;
    logic             c_in_out;
    logic [WIDTH-1:0] carry_in;

    // result side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    // datapath view
    modport slave (
        input  in_valid, a, b, sub, carry_in, out_ready,
        output in_ready, g_out, p_out, c_in_out, out_valid, sum, cout, ovf, zero
    );

    // producer / carry generator / consumer view
    modport master (
        output in_valid, a, b, sub, carry_in, out_ready,
        input  in_ready, g_out, p_out, c_in_out, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - two-stage add/subtract pipeline around an external carry look-ahead generator
module cla_addsub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_addsub_pipe_if.slave     bus
);
    // stage 1: operands with B already conditioned for subtraction
    logic             s1Valid;
    logic [WIDTH-1:0] s1A;
    logic [WIDTH-1:0] s1Bx;
    logic             s1Cin;

    // stage 2: registered result and flags
    logic             outValid;
    logic [WIDTH-1:0] sumReg;
    logic             coutReg;
    logic             ovfReg;
    logic             zeroReg;

    logic             s2Take;
    logic             inReady;
    logic             inAccept;
    logic             s1Advance;
    logic [WIDTH-1:0] pVec;
    logic [WIDTH-1:0] sumNext;

    assign s2Take    = !outValid | bus.out_ready;
    assign inReady   = !s1Valid | s2Take;
    assign inAccept  = bus.in_valid & inReady;
    assign s1Advance = s1Valid & s2Take;

    // propagate is used ungated for the sum; the exported vectors are quiet when S1 is empty
    assign pVec         = s1A ^ s1Bx;
    assign bus.g_out    = s1Valid ? (s1A & s1Bx) : '0;
    assign bus.p_out    = s1Valid ? pVec : '0;
    assign bus.c_in_out = s1Valid & s1Cin;

    // carry into bit i is carry out of bit i-1, with the stage carry-in feeding bit 0
    assign sumNext = pVec ^ {bus.carry_in[WIDTH-2:0], s1Cin};

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.sum       = sumReg;
    assign bus.cout      = coutReg;
    assign bus.ovf       = ovfReg;
    assign bus.zero      = zeroReg;

    // stage 1: load on accept, empty when it advances without a replacement
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid <= 1'b0;
            s1A     <= '0;
            s1Bx    <= '0;
            s1Cin   <= 1'b0;
        end else if (inAccept) begin
            s1Valid <= 1'b1;
            s1A     <= bus.a;
            s1Bx    <= bus.sub ? ~bus.b : bus.b;
            s1Cin   <= bus.sub;
        end else if (s1Advance) begin
            s1Valid <= 1'b0;
        end
    end

    // stage 2: capture result when S1 advances, hold while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid <= 1'b0;
            sumReg   <= '0;
            coutReg  <= 1'b0;
            ovfReg   <= 1'b0;
            zeroReg  <= 1'b0;
        end else if (s1Advance) begin
            outValid <= 1'b1;
            sumReg   <= sumNext;
            coutReg  <= bus.carry_in[WIDTH-1];
            ovfReg   <= bus.carry_in[WIDTH-1] ^ bus.carry_in[WIDTH-2];
            zeroReg  <= (sumNext == '0);
        end else if (bus.out_ready) begin
            outValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb/tb_cla_addsub_pipe.sv - self-checking bench for cla_addsub_pipe
module tb_cla_addsub_pipe;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cla_addsub_pipe_if #(.WIDTH(W)) bus ();

    cla_addsub_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ripple formulation of the external carry generator
    function automatic logic [W-1:0] claCarry(input logic [W-1:0] g, input logic [W-1:0] p, input logic cin);
        logic [W-1:0] r;
        logic         c;
        c = cin;
        for (int i = 0; i < W; i++) begin
            c    = g[i] | (p[i] & c);
            r[i] = c;
        end
        return r;
    endfunction

    assign bus.carry_in = claCarry(bus.g_out, bus.p_out, bus.c_in_out);

    // reference result from integer arithmetic
    function automatic res_t refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        res_t e;
        int   sa;
        int   sb;
        int   r;
        int   ua;
        int   ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = int'(a);
        ub = int'(b);
        if (sub) begin
            r      = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            r      = sa + sb;
            e.cout = ((ua + ub) >= (1 << W));
        end
        e.sum  = r[W-1:0];
        e.ovf  = (r > ((1 << (W-1)) - 1)) || (r < -(1 << (W-1)));
        e.zero = (e.sum == '0);
        return e;
    endfunction

    function automatic res_t observed();
        res_t o;
        o.sum  = bus.sum;
        o.cout = bus.cout;
        o.ovf  = bus.ovf;
        o.zero = bus.zero;
        return o;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one isolated operation with the consumer always ready
    task automatic doOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic [W-1:0] eSum, input logic eCout, input logic eOvf, input logic eZero);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.sub       = sub;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_latency_early"}, bus.out_valid, 1'b0);
        @(negedge clk);
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check({tag, "_sum"},   bus.sum,  eSum);
        check({tag, "_cout"},  bus.cout, eCout);
        check({tag, "_ovf"},   bus.ovf,  eOvf);
        check({tag, "_zero"},  bus.zero, eZero);
    endtask

    res_t q[$];
    res_t heldRes;
    res_t expRes;
    logic holding;
    int   inFlight;
    int   sent;
    logic acc;
    logic cons;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_sum",       bus.sum,       '0);
        check("rst_zero",      bus.zero,      1'b0);
        check("rst_cout_ovf",  {bus.cout, bus.ovf}, 2'b00);
        check("rst_in_ready",  bus.in_ready,  1'b1);
        check("rst_gp",        {bus.g_out, bus.p_out, bus.c_in_out}, '0);

        doOp("add_7f_01",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        doOp("sub_05_05",  8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        doOp("sub_03_05",  8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        doOp("add_ff_01",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        doOp("sub_b_zero", 8'h9C, 8'h00, 1'b1, 8'h9C, 1'b1, 1'b0, 1'b0);

        // generate/propagate export while S1 holds A5 - 3C, then with S1 empty
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = 8'hA5;
        bus.b         = 8'h3C;
        bus.sub       = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("gp_g_out",    bus.g_out,    8'h81);
        check("gp_p_out",    bus.p_out,    8'h66);
        check("gp_c_in_out", bus.c_in_out, 1'b1);
        @(negedge clk);
        check("gp_empty", {bus.g_out, bus.p_out, bus.c_in_out}, '0);
        check("gp_result", observed(), refModel(8'hA5, 8'h3C, 1'b1));

        // fill both stages under stall, then reset
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 8'h11;
        bus.b         = 8'h22;
        bus.sub       = 1'b0;
        @(negedge clk);
        bus.a = 8'h33;
        @(negedge clk);
        #1;
        check("full_in_ready",  bus.in_ready,  1'b0);
        check("full_out_valid", bus.out_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_sum",       bus.sum,       '0);
        check("mid_rst_zero",      bus.zero,      1'b0);
        check("mid_rst_in_ready",  bus.in_ready,  1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_no_stale", bus.out_valid, 1'b0);
        end

        // random stream with random consumer back-pressure
        inFlight = 0;
        sent     = 0;
        holding  = 1'b0;
        for (int cyc = 0; cyc < 400 && (sent < 16 || q.size() > 0); cyc++) begin
            @(negedge clk);
            if (holding) begin
                check("stall_stable", observed(), heldRes);
            end
            bus.in_valid  = (sent < 16) ? ($urandom_range(0, 3) != 0) : 1'b0;
            bus.a         = W'($urandom);
            bus.b         = W'($urandom);
            bus.sub       = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            check("in_ready", bus.in_ready, !(inFlight == 2 && !bus.out_ready));
            acc  = bus.in_valid & bus.in_ready;
            cons = bus.out_valid & bus.out_ready;
            if (cons) begin
                check("no_spurious_beat", q.size() > 0, 1'b1);
                if (q.size() > 0) begin
                    expRes = q.pop_front();
                    check("stream_result", observed(), expRes);
                end
            end
            holding = bus.out_valid & !bus.out_ready;
            heldRes = observed();
            if (acc) begin
                q.push_back(refModel(bus.a, bus.b, bus.sub));
                sent++;
            end
            inFlight = inFlight + int'(acc) - int'(cons);
        end
        check("stream_drained", (q.size() == 0) && (sent == 16), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
